// File: rtl/wb_pkg.sv
// Shared types and default sizes for the writeback arbiter.
// Optional build macro honoured by wb_arbiter: WB_R0_DISCARD_EN.
package wb_pkg;

  localparam int WB_WIDTH  = 8;
  localparam int WB_DEPTH  = 16;
  localparam int WB_AW     = $clog2(WB_DEPTH);
  localparam int WB_QDEPTH = 2;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

  // Default-sized request; wb_arbiter re-declares it from its own parameters.
  typedef struct packed {
    logic [WB_AW-1:0]    addr;
    logic [WB_WIDTH-1:0] data;
  } wb_req_t;

  function automatic wb_src_e wb_other(input wb_src_e s);
    return (s == WB_SRC_ALU) ? WB_SRC_LSU : WB_SRC_ALU;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO; exposes its storage and per-slot valid mask so the
// parent can search pending destinations.
module wb_fifo #(
  parameter int W      = 12,
  parameter int QDEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [W-1:0]               head,
  output logic [QDEPTH-1:0][W-1:0]   entries,
  output logic [QDEPTH-1:0]          valid_mask
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;

  logic [PW-1:0]             wr_ptr;
  logic [PW-1:0]             rd_ptr;
  logic [CW-1:0]             count;
  logic [QDEPTH-1:0][W-1:0]  mem;
  logic                      do_push;
  logic                      do_pop;

  assign full    = (count == CW'(QDEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign entries = mem;

  // Slot i is live when its distance from the read pointer is below count.
  for (genvar i = 0; i < QDEPTH; i++) begin : g_valid
    assign valid_mask[i] = ({1'b0, PW'(PW'(i) - rd_ptr)} < count);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      mem    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: queues ALU and LSU results, round-robin grants one per
// cycle into a registered register-file write port. Macro: WB_R0_DISCARD_EN.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter  int WIDTH  = WB_WIDTH,
  parameter  int DEPTH  = WB_DEPTH,
  parameter  int QDEPTH = WB_QDEPTH,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [AW-1:0]     alu_addr,
  input  logic [WIDTH-1:0]  alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [AW-1:0]     lsu_addr,
  input  logic [WIDTH-1:0]  lsu_data,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  input  logic [AW-1:0]     sb_addr,
  output logic              sb_pending
);

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } req_t;

  localparam int RW = $bits(req_t);

`ifdef WB_R0_DISCARD_EN
  localparam bit R0_DISCARD = 1'b1;
`else
  localparam bit R0_DISCARD = 1'b0;
`endif

  // Handshake: a result transfers on a rising edge where valid && ready;
  // ready means the source queue is not full and is forced low during reset.
  // Producers hold addr/data steady while valid && !ready.

  logic                     alu_full, alu_empty, lsu_full, lsu_empty;
  logic                     alu_push, lsu_push, alu_pop, lsu_pop;
  req_t                     alu_head, lsu_head, grant_req;
  req_t [QDEPTH-1:0]        alu_ent, lsu_ent;
  logic [QDEPTH-1:0]        alu_vm, lsu_vm;
  wb_src_e                  rr_q, rr_d;
  logic                     grant, wr_load;
  logic                     wr_en_q;
  logic [AW-1:0]            wr_addr_q;
  logic [WIDTH-1:0]         wr_data_q;

  assign alu_ready = !alu_full && !rst;
  assign lsu_ready = !lsu_full && !rst;
  assign alu_push  = alu_valid && alu_ready;
  assign lsu_push  = lsu_valid && lsu_ready;

  wb_fifo #(.W(RW), .QDEPTH(QDEPTH)) u_alu_q (
    .clk        (clk),
    .rst        (rst),
    .push       (alu_push),
    .push_data  ({alu_addr, alu_data}),
    .pop        (alu_pop),
    .full       (alu_full),
    .empty      (alu_empty),
    .head       (alu_head),
    .entries    (alu_ent),
    .valid_mask (alu_vm)
  );

  wb_fifo #(.W(RW), .QDEPTH(QDEPTH)) u_lsu_q (
    .clk        (clk),
    .rst        (rst),
    .push       (lsu_push),
    .push_data  ({lsu_addr, lsu_data}),
    .pop        (lsu_pop),
    .full       (lsu_full),
    .empty      (lsu_empty),
    .head       (lsu_head),
    .entries    (lsu_ent),
    .valid_mask (lsu_vm)
  );

  // A lone head always wins; the pointer then favours the other source.
  always_comb begin
    alu_pop   = 1'b0;
    lsu_pop   = 1'b0;
    rr_d      = rr_q;
    if (!alu_empty && (lsu_empty || rr_q == WB_SRC_ALU)) begin
      alu_pop = 1'b1;
      rr_d    = wb_other(WB_SRC_ALU);
    end else if (!lsu_empty) begin
      lsu_pop = 1'b1;
      rr_d    = wb_other(WB_SRC_LSU);
    end
    grant     = alu_pop || lsu_pop;
    grant_req = lsu_pop ? lsu_head : alu_head;
    wr_load   = grant && (!R0_DISCARD || grant_req.addr != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q      <= WB_SRC_ALU;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      rr_q    <= rr_d;
      wr_en_q <= wr_load;
      if (wr_load) begin
        wr_addr_q <= grant_req.addr;
        wr_data_q <= grant_req.data;
      end
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

  // Discarded R0 entries never reach the file, so they never count as pending.
  always_comb begin
    sb_pending = wr_en_q && (wr_addr_q == sb_addr);
    for (int i = 0; i < QDEPTH; i++) begin
      if (alu_vm[i] && alu_ent[i].addr == sb_addr &&
          (!R0_DISCARD || alu_ent[i].addr != '0)) begin
        sb_pending = 1'b1;
      end
      if (lsu_vm[i] && lsu_ent[i].addr == sb_addr &&
          (!R0_DISCARD || lsu_ent[i].addr != '0)) begin
        sb_pending = 1'b1;
      end
    end
  end

endmodule
